ioctl_loader_arb: RTL and testbench

IOCTL_LOADER_ARB -- requirements
Module: ioctl_loader_arb

---
 rtl/ioctl_loader_pkg.sv | 19 +
 rtl/ioctl_loader_fifo.sv | 57 +++++
 rtl/ioctl_loader_arb.sv | 146 ++++++++++++++
 tb/tb_ioctl_loader_arb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// Types shared by the ioctl ROM loader: FSM states, ROM address width and write-buffer entry.
// No logic; latency and backpressure are defined by the modules that import it.
package ioctl_loader_pkg;

  localparam int ROM_AW = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [7:0]        data;
  } fifo_entry_t;

endpackage

// File: rtl/ioctl_loader_fifo.sv
// Loader write buffer: head visible combinationally, push lands one cycle later.
// Pushes while full and pops while empty are ignored; the caller owns overflow reporting.
module ioctl_loader_fifo
  import ioctl_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   push,
  input  fifo_entry_t            push_dat,
  input  logic                   pop,
  output fifo_entry_t            head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fifo_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign head_dat = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ioctl_loader_arb.sv
// HPS ROM download buffered into a shared memory port; video wins unless the loader starves (optional IOCTL_LOADER_CHECKSUM_EN).
// Grant/mem outputs are combinational, vid_rdata follows one cycle later; ioctl_wait asserts at FIFO_DEPTH-1 entries.
module ioctl_loader_arb
  import ioctl_loader_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'h00,
  parameter int         STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic              vid_req,
  input  logic [ROM_AW-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_rdata,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              loaded,
  output logic              load_done,
`ifdef IOCTL_LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              overflow
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int            SW       = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_enter_load;
  logic [SW-1:0] r_starve;
  logic          r_wait;
  logic          r_overflow;
  logic          r_load_done;
  logic          r_vid_pend;
  logic [7:0]    r_rdata_hold;
  fifo_entry_t   w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_match;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_ld_gnt;
  logic          w_vid_gnt;

  assign w_match    = ioctl_download && (ioctl_index == ROM_INDEX);
  assign w_push_req = (r_state == ST_LOAD) && ioctl_wr && (ioctl_addr[24:17] == 8'h00);
  assign w_push_ok  = w_push_req && !w_full;
  assign w_ld_gnt   = !w_empty && (!vid_req || (r_starve >= STARVE_C));
  // Gating with reset_n keeps the video handshake quiet while reset is held.
  assign w_vid_gnt  = reset_n && vid_req && !w_ld_gnt;

  ioctl_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push     (w_push_ok),
    .push_dat ({ioctl_addr[ROM_AW-1:0], ioctl_dout}),
    .pop      (w_ld_gnt),
    .head_dat (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_match) begin
          w_state_nxt  = ST_LOAD;
          w_enter_load = 1'b1;
        end
      end
      ST_LOAD:  if (!ioctl_download) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty && !w_ld_gnt) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = w_count;
    if (w_push_ok && !w_ld_gnt)      w_count_nxt = w_count + 1'b1;
    else if (!w_push_ok && w_ld_gnt) w_count_nxt = w_count - 1'b1;
  end

  // ioctl_wait is registered from next occupancy so it tracks the FIFO count cycle for cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_starve     <= '0;
      r_wait       <= 1'b0;
      r_overflow   <= 1'b0;
      r_load_done  <= 1'b0;
      r_vid_pend   <= 1'b0;
      r_rdata_hold <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= ((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_DRAIN)) &&
                     (w_count_nxt >= WAIT_CNT);
      r_load_done <= (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);
      r_vid_pend  <= w_vid_gnt;
      if (r_vid_pend) r_rdata_hold <= mem_rdata;
      if (w_ld_gnt)      r_starve <= '0;
      else if (!w_empty) r_starve <= r_starve + 1'b1;
      if (w_enter_load)                r_overflow <= 1'b0;
      else if (w_push_req && w_full)   r_overflow <= 1'b1;
    end
  end

`ifdef IOCTL_LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)          r_checksum <= 8'h00;
    else if (w_enter_load) r_checksum <= 8'h00;
    else if (w_ld_gnt)     r_checksum <= r_checksum + w_head.data;
  end

  assign checksum = r_checksum;
`endif

  assign ioctl_wait = r_wait;
  assign vid_ack    = w_vid_gnt;
  assign vid_rdata  = r_vid_pend ? mem_rdata : r_rdata_hold;
  assign mem_we     = w_ld_gnt;
  assign mem_addr   = w_ld_gnt ? w_head.addr : (w_vid_gnt ? vid_addr : '0);
  assign mem_wdata  = w_ld_gnt ? w_head.data : 8'h00;
  assign loaded     = (r_state == ST_DONE);
  assign load_done  = r_load_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ioctl_loader_arb.sv
// Directed bench for ioctl_loader_arb: download ordering, index filtering, starvation, overflow, reset.
// Memory model returns addr[7:0]^0x5A with one cycle of latency.
module tb_ioctl_loader_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic        vid_req;
  logic [16:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic        loaded;
  logic        load_done;
  logic        overflow;
`ifdef IOCTL_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          ld_cnt = 0;
  logic [24:0] wlog [$];

  always #5 clk = ~clk;

  ioctl_loader_arb dut (
    .clk_sys        (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .vid_req        (vid_req),
    .vid_addr       (vid_addr),
    .vid_ack        (vid_ack),
    .vid_rdata      (vid_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata),
    .loaded         (loaded),
    .load_done      (load_done),
`ifdef IOCTL_LOADER_CHECKSUM_EN
    .checksum       (checksum),
`endif
    .overflow       (overflow)
  );

  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
    if (load_done === 1'b1) ld_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    cyc;
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_loaded(input string tag);
    int n;
    n = 0;
    while (loaded !== 1'b1 && n < 80) begin
      cyc;
      n++;
    end
    smp;
    check(tag, loaded, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = 8'h00;
    vid_req        = 1'b1;
    vid_addr       = 17'h01234;
    cyc;
    smp;
    check("rst_wait", ioctl_wait, 0);
    check("rst_vid_ack", vid_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    check("rst_loaded", loaded, 0);
    check("rst_load_done", load_done, 0);
    check("rst_overflow", overflow, 0);
    vid_req = 1'b0;
    cyc;
    reset_n = 1'b1;

    // Plain 16-byte download with no video traffic
    wlog.delete();
    ld_cnt = 0;
    ioctl_download = 1'b1;
    cyc;
    for (int i = 0; i < 16; i++) wr_byte(25'(i), 8'h10 + 8'(i));
    ioctl_download = 1'b0;
    wait_loaded("t1_loaded");
    repeat (4) cyc;
    smp;
    check("t1_nwrites", wlog.size(), 16);
    for (int i = 0; i < 16 && i < wlog.size(); i++)
      check($sformatf("t1_write%0d", i), wlog[i], {17'(i), 8'h10 + 8'(i)});
    check("t1_done_pulses", ld_cnt, 1);
    check("t1_loaded_hold", loaded, 1);
    check("t1_wait_idle", ioctl_wait, 0);

    // Non-matching index is ignored
    reset_n = 1'b0;
    cyc;
    reset_n = 1'b1;
    wlog.delete();
    ioctl_index    = 8'h01;
    ioctl_download = 1'b1;
    vid_req        = 1'b1;
    cyc;
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'hC0 + 8'(i));
    ioctl_download = 1'b0;
    repeat (3) cyc;
    smp;
    check("t2_wait", ioctl_wait, 0);
    vid_req = 1'b0;
    repeat (12) cyc;
    smp;
    check("t2_nwrites", wlog.size(), 0);
    check("t2_loaded", loaded, 0);

    // Address range filter: 0x20000 dropped, 0x1FFFF written
    wlog.delete();
    ioctl_index    = 8'h00;
    ioctl_download = 1'b1;
    cyc;
    wr_byte(25'h0020000, 8'h77);
    wr_byte(25'h001FFFF, 8'hA5);
    ioctl_download = 1'b0;
    smp;
    check("t3_mem_we", mem_we, 1);
    check("t3_mem_addr", mem_addr, 17'h1FFFF);
    check("t3_mem_wdata", mem_wdata, 8'hA5);
    wait_loaded("t3_loaded");
    check("t3_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) check("t3_write0", wlog[0], {17'h1FFFF, 8'hA5});

    // Starvation: video held, 3 bytes; loader gets cycles 9, 18, 27
    wlog.delete();
    vid_req        = 1'b1;
    vid_addr       = 17'h0A000;
    ioctl_download = 1'b1;
    cyc;
    smp;
    check("t4_loaded_clr", loaded, 0);
    for (int k = 0; k <= 30; k++) begin
      cyc;
      vid_addr = 17'h0A000 + 17'(k);
      if (k < 3) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h100 + 25'(k);
        ioctl_dout = 8'h31 + 8'(k);
      end else begin
        ioctl_wr = 1'b0;
      end
      if (k == 3) ioctl_download = 1'b0;
      smp;
      check($sformatf("t4_ack%0d", k), vid_ack, (k == 9 || k == 18 || k == 27) ? 0 : 1);
      if (k == 5)  check("t4_rdata5", vid_rdata, 8'h04 ^ 8'h5A);
      if (k == 5)  check("t4_vaddr5", mem_addr, 17'h0A005);
      if (k == 9)  check("t4_addr9", mem_addr, 17'h00100);
      if (k == 10) check("t4_rdata_hold", vid_rdata, 8'h08 ^ 8'h5A);
      if (k == 27) check("t4_wdata27", mem_wdata, 8'h33);
    end
    wait_loaded("t4_loaded");
    check("t4_nwrites", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      check($sformatf("t4_write%0d", i), wlog[i], {17'h100 + 17'(i), 8'h31 + 8'(i)});

    // Overflow: 6 back-to-back bytes into a 4-entry buffer with video held
    wlog.delete();
    vid_addr       = 17'h00055;
    ioctl_download = 1'b1;
    cyc;
    for (int k = 0; k <= 40; k++) begin
      cyc;
      if (k < 6) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h200 + 25'(k);
        ioctl_dout = 8'h40 + 8'(k);
      end else begin
        ioctl_wr = 1'b0;
      end
      if (k == 6) ioctl_download = 1'b0;
      smp;
      if (k == 2)  check("t5_wait2", ioctl_wait, 0);
      if (k == 3)  check("t5_wait3", ioctl_wait, 1);
      if (k == 4)  check("t5_ovf4", overflow, 0);
      if (k == 5)  check("t5_ovf5", overflow, 1);
      if (k == 8)  check("t5_wait8", ioctl_wait, 1);
      if (k == 18) check("t5_wait18", ioctl_wait, 1);
      if (k == 19) check("t5_wait19", ioctl_wait, 0);
    end
    wait_loaded("t5_loaded");
    check("t5_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check($sformatf("t5_write%0d", i), wlog[i], {17'h200 + 17'(i), 8'h40 + 8'(i)});
    check("t5_ovf_sticky", overflow, 1);

    // Reset with two bytes buffered
    wlog.delete();
    ioctl_download = 1'b1;
    cyc;
    smp;
    check("t6_ovf_clr", overflow, 0);
    cyc;
    wr_byte(25'h300, 8'hEE);
    wr_byte(25'h301, 8'hEF);
    smp;
    reset_n = 1'b0;
    #1;
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_ack", vid_ack, 0);
    check("t6_rst_addr", mem_addr, 0);
    ioctl_download = 1'b0;
    cyc;
    cyc;
    reset_n = 1'b1;
    vid_req = 1'b0;
    smp;
    check("t6_post_we", mem_we, 0);
    repeat (10) cyc;
    smp;
    check("t6_nwrites", wlog.size(), 0);
    check("t6_loaded", loaded, 0);

`ifdef IOCTL_LOADER_CHECKSUM_EN
    ioctl_download = 1'b1;
    cyc;
    wr_byte(25'h0, 8'h01);
    wr_byte(25'h1, 8'hFF);
    wr_byte(25'h2, 8'h02);
    ioctl_download = 1'b0;
    wait_loaded("t7_loaded");
    check("t7_checksum", checksum, 8'h02);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
